// File: rtl/bu_ctrl_pkg.sv
// Shared types and address generation for the NTT/INTT butterfly sequencer.
package bu_ctrl_pkg;

  localparam int BU_N        = 256;
  localparam int BU_LOG_N    = 8;
  localparam int BU_AW       = 8;
  localparam int BU_PIPE_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bu_state_e;

  // One butterfly: coefficient pair (j, j+len) and its zeta-ROM index.
  typedef struct packed {
    logic [BU_AW-1:0] addr_a;
    logic [BU_AW-1:0] addr_b;
    logic [BU_AW-1:0] zeta;
  } bu_addr_t;

  // Address pair and zeta index of butterfly b in stage s.
  // fwd=1: len halves per stage (N/2 .. 1), zeta climbs 1..N-1.
  // fwd=0: len doubles per stage (1 .. N/2), zeta falls N-1..1.
  // Arithmetic is done in 32 bits and truncated to BU_AW on return, so it
  // serves transforms of up to 2**BU_AW points.
  function automatic bu_addr_t bu_addr_gen(input logic [31:0] s,
                                           input logic [31:0] b,
                                           input logic        fwd,
                                           input logic [31:0] log_n);
    logic [31:0] m;
    logic [31:0] len;
    logic [31:0] g;
    logic [31:0] j;
    logic [31:0] z;
    bu_addr_t    r;
    m   = fwd ? (log_n - 32'd1 - s) : s;
    len = 32'd1 << m;
    g   = b >> m;
    j   = (g << (m + 32'd1)) | (b & (len - 32'd1));
    z   = fwd ? ((32'd1 << s) + g) : (((32'd1 << log_n) >> s) - 32'd1 - g);
    r.addr_a = j[BU_AW-1:0];
    r.addr_b = 32'(j + len) & ((32'd1 << BU_AW) - 32'd1);
    r.zeta   = z[BU_AW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/bu_wb_delay.sv
// Write-back delay line: carries (valid, addr_a, addr_b) DEPTH cycles so the
// write strobe lines up with the butterfly result. Cleared asynchronously.
module bu_wb_delay #(
  parameter int AW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          valid_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [AW-1:0] addr_b_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_a_o,
  output logic [AW-1:0] addr_b_o
);

  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    addr_a_q [DEPTH];
  logic [AW-1:0]    addr_b_q [DEPTH];

  // Shift every cycle; a reset drops all in-flight writes.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        addr_a_q[i] <= '0;
        addr_b_q[i] <= '0;
      end
    end else begin
      valid_q[0]  <= valid_i;
      addr_a_q[0] <= addr_a_i;
      addr_b_q[0] <= addr_b_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i]  <= valid_q[i-1];
        addr_a_q[i] <= addr_a_q[i-1];
        addr_b_q[i] <= addr_b_q[i-1];
      end
    end
  end

  assign valid_o  = valid_q[DEPTH-1];
  assign addr_a_o = addr_a_q[DEPTH-1];
  assign addr_b_o = addr_b_q[DEPTH-1];

endmodule

// File: rtl/bu_stage_sched.sv
// Butterfly stage sequencer for a radix-2 NTT/INTT: walks LOG_N stages of
// N/2 butterflies, one per cycle, then drains the pipeline before each next
// stage so a read never overtakes the previous stage's last write.
//
// Handshake: start_i is a level sampled only in IDLE; a sampled start begins a
// transform and further start_i is ignored until IDLE is re-entered. done_o is
// a one-cycle pulse in the DONE cycle; busy_o is high from the first read
// cycle through DONE. The RAM and BU have no back-pressure: rd_en_o and
// wr_en_o are one-cycle strobes that are always accepted.
module bu_stage_sched
  import bu_ctrl_pkg::*;
#(
  parameter int N        = BU_N,
  parameter int LOG_N    = BU_LOG_N,
  parameter int AW       = BU_AW,
  parameter int PIPE_LAT = BU_PIPE_LAT,
  localparam int SW      = (LOG_N > 1) ? $clog2(LOG_N) : 1
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            start_i,
  input  logic            mode_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            is_gs_bu_o,
  output logic            rd_en_o,
  output logic [AW-1:0]   rd_addr_a_o,
  output logic [AW-1:0]   rd_addr_b_o,
  output logic [AW-1:0]   zeta_addr_o,
  output logic            wr_en_o,
  output logic [AW-1:0]   wr_addr_a_o,
  output logic [AW-1:0]   wr_addr_b_o,
  output logic [SW-1:0]   stage_o,
  output bu_state_e       dbg_state_o
);

  localparam int BW = (N > 4) ? $clog2(N/2) : 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(N/2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  bu_state_e     state_q;
  logic [SW-1:0] s_q;
  logic [BW-1:0] b_q;
  logic [DW-1:0] d_q;
  logic          mode_q;
  logic          busy_q;
  logic          done_q;
  logic          rd_en_q;
  logic [AW-1:0] rd_a_q;
  logic [AW-1:0] rd_b_q;
  logic [AW-1:0] zeta_q;

  logic [SW-1:0] gen_s;
  logic [BW-1:0] gen_b;
  logic          gen_fwd;
  bu_addr_t      nxt;

  // Butterfly that will be issued at the next edge, if any: the first of a
  // transform (IDLE), the first of the next stage (DRAIN) or the next in the
  // current stage (RUN).
  always_comb begin
    gen_s   = s_q;
    gen_b   = b_q + BW'(1);
    gen_fwd = mode_q;
    if (state_q == IDLE) begin
      gen_s   = '0;
      gen_b   = '0;
      gen_fwd = mode_i;
    end else if (state_q == DRAIN) begin
      gen_s = s_q + SW'(1);
      gen_b = '0;
    end
  end

  assign nxt = bu_addr_gen(32'(gen_s), 32'(gen_b), gen_fwd, 32'(LOG_N));

  // Sequencer FSM with registered read-side outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      zeta_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= RUN;
            mode_q  <= mode_i;
            s_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            rd_a_q  <= AW'(nxt.addr_a);
            rd_b_q  <= AW'(nxt.addr_b);
            zeta_q  <= AW'(nxt.zeta);
          end
        end
        RUN: begin
          if (b_q == B_LAST) begin
            state_q <= DRAIN;
            d_q     <= '0;
          end else begin
            b_q     <= gen_b;
            rd_en_q <= 1'b1;
            rd_a_q  <= AW'(nxt.addr_a);
            rd_b_q  <= AW'(nxt.addr_b);
            zeta_q  <= AW'(nxt.zeta);
          end
        end
        DRAIN: begin
          if (d_q == D_LAST) begin
            if (s_q == S_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              s_q     <= gen_s;
              b_q     <= '0;
              rd_en_q <= 1'b1;
              rd_a_q  <= AW'(nxt.addr_a);
              rd_b_q  <= AW'(nxt.addr_b);
              zeta_q  <= AW'(nxt.zeta);
            end
          end else begin
            d_q <= d_q + DW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          s_q     <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bu_wb_delay #(
    .AW    (AW),
    .DEPTH (PIPE_LAT)
  ) u_wb_delay (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .valid_i  (rd_en_q),
    .addr_a_i (rd_a_q),
    .addr_b_i (rd_b_q),
    .valid_o  (wr_en_o),
    .addr_a_o (wr_addr_a_o),
    .addr_b_o (wr_addr_b_o)
  );

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign is_gs_bu_o  = mode_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_a_o = rd_a_q;
  assign rd_addr_b_o = rd_b_q;
  assign zeta_addr_o = zeta_q;
  assign stage_o     = s_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bu_stage_sched.sv
// Bench for bu_stage_sched: per-cycle comparison against a schedule built
// from the textbook NTT/INTT loop nests, for PIPE_LAT=2 and PIPE_LAT=3.
module tb_bu_stage_sched;
  import bu_ctrl_pkg::*;

  localparam int N     = 256;
  localparam int LOG_N = 8;
  localparam int MAXC  = 1100;

  logic clk;
  logic reset_n;
  logic start;
  logic mode;
  logic sel;
  logic start2;
  logic start3;

  logic       busy2, done2, gs2, rden2, wren2;
  logic [7:0] ra2, rb2, z2, wa2, wb2;
  logic [2:0] st2;
  bu_state_e  fsm2;
  logic       busy3, done3, gs3, rden3, wren3;
  logic [7:0] ra3, rb3, z3, wa3, wb3;
  logic [2:0] st3;
  bu_state_e  fsm3;

  logic       o_busy, o_done, o_gs, o_rden, o_wren;
  logic [7:0] o_ra, o_rb, o_z, o_wa, o_wb;
  logic [2:0] o_st;
  bu_state_e  o_fsm;

  int n_checks;
  int n_fail;

  int e_busy [MAXC];
  int e_done [MAXC];
  int e_rden [MAXC];
  int e_ra   [MAXC];
  int e_rb   [MAXC];
  int e_z    [MAXC];
  int e_wren [MAXC];
  int e_wa   [MAXC];
  int e_wb   [MAXC];
  int e_st   [MAXC];

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign start2 = start & ~sel;
  assign start3 = start & sel;

  bu_stage_sched dut2 (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start2), .mode_i(mode),
    .busy_o(busy2), .done_o(done2), .is_gs_bu_o(gs2), .rd_en_o(rden2),
    .rd_addr_a_o(ra2), .rd_addr_b_o(rb2), .zeta_addr_o(z2),
    .wr_en_o(wren2), .wr_addr_a_o(wa2), .wr_addr_b_o(wb2),
    .stage_o(st2), .dbg_state_o(fsm2)
  );

  bu_stage_sched #(.PIPE_LAT(3)) dut3 (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start3), .mode_i(mode),
    .busy_o(busy3), .done_o(done3), .is_gs_bu_o(gs3), .rd_en_o(rden3),
    .rd_addr_a_o(ra3), .rd_addr_b_o(rb3), .zeta_addr_o(z3),
    .wr_en_o(wren3), .wr_addr_a_o(wa3), .wr_addr_b_o(wb3),
    .stage_o(st3), .dbg_state_o(fsm3)
  );

  // Observe whichever instance is under test.
  always_comb begin
    if (sel) begin
      o_busy = busy3; o_done = done3; o_gs = gs3; o_rden = rden3; o_wren = wren3;
      o_ra = ra3; o_rb = rb3; o_z = z3; o_wa = wa3; o_wb = wb3; o_st = st3; o_fsm = fsm3;
    end else begin
      o_busy = busy2; o_done = done2; o_gs = gs2; o_rden = rden2; o_wren = wren2;
      o_ra = ra2; o_rb = rb2; o_z = z2; o_wa = wa2; o_wb = wb2; o_st = st2; o_fsm = fsm2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"},  32'(o_busy), 32'd0);
    chk({tag, " done"},  32'(o_done), 32'd0);
    chk({tag, " gs"},    32'(o_gs),   32'd0);
    chk({tag, " rd_en"}, 32'(o_rden), 32'd0);
    chk({tag, " rd_a"},  32'(o_ra),   32'd0);
    chk({tag, " rd_b"},  32'(o_rb),   32'd0);
    chk({tag, " zeta"},  32'(o_z),    32'd0);
    chk({tag, " wr_en"}, 32'(o_wren), 32'd0);
    chk({tag, " wr_a"},  32'(o_wa),   32'd0);
    chk({tag, " wr_b"},  32'(o_wb),   32'd0);
    chk({tag, " stage"}, 32'(o_st),   32'd0);
    chk({tag, " state"}, 32'(o_fsm),  32'(IDLE));
  endtask

  // Record one butterfly of stage s, position idx, into the cycle schedule.
  task automatic put_bf(input int pl, input int s, input int idx,
                        input int a, input int b, input int z);
    int c;
    c = 1 + s * (N/2 + pl) + idx;
    e_rden[c] = 1; e_ra[c] = a; e_rb[c] = b; e_z[c] = z;
    e_wren[c+pl] = 1; e_wa[c+pl] = a; e_wb[c+pl] = b;
  endtask

  // Expected cycle-by-cycle schedule from the reference NTT/INTT loop nests.
  task automatic build_model(input logic fwd, input int pl);
    int t, k, s, idx;
    t = 1 + LOG_N * (N/2 + pl);
    for (int c = 0; c < MAXC; c++) begin
      e_busy[c] = 0; e_done[c] = 0; e_rden[c] = 0; e_ra[c] = 0; e_rb[c] = 0;
      e_z[c] = 0; e_wren[c] = 0; e_wa[c] = 0; e_wb[c] = 0; e_st[c] = 0;
    end
    for (int c = 1; c <= t; c++) e_busy[c] = 1;
    e_done[t] = 1;
    for (int st = 0; st < LOG_N; st++)
      for (int c = 1 + st * (N/2 + pl); c < 1 + (st + 1) * (N/2 + pl); c++) e_st[c] = st;
    e_st[t] = LOG_N - 1;
    s = 0;
    if (fwd) begin
      k = 0;
      for (int len = N/2; len >= 1; len = len / 2) begin
        idx = 0;
        for (int grp = 0; grp < N; grp += 2 * len) begin
          k++;
          for (int j = grp; j < grp + len; j++) begin
            put_bf(pl, s, idx, j, j + len, k);
            idx++;
          end
        end
        s++;
      end
    end else begin
      k = N;
      for (int len = 1; len < N; len = len * 2) begin
        idx = 0;
        for (int grp = 0; grp < N; grp += 2 * len) begin
          k--;
          for (int j = grp; j < grp + len; j++) begin
            put_bf(pl, s, idx, j, j + len, k);
            idx++;
          end
        end
        s++;
      end
    end
  endtask

  // Check one transform cycle by cycle; caller has driven start for edge 0.
  // policy 1 keeps start high for the first half and pulses it afterwards.
  task automatic check_run(input logic fwd, input int pl, input int policy,
                           input logic restart, input logic next_mode, input int stop);
    int t, wr_cnt;
    string tg;
    build_model(fwd, pl);
    t = 1 + LOG_N * (N/2 + pl);
    wr_cnt = 0;
    for (int c = 1; c <= t + 1; c++) begin
      @(negedge clk);
      tg = $sformatf("pl%0d c%0d", pl, c);
      chk({"busy ", tg},  32'(o_busy), 32'(e_busy[c]));
      chk({"done ", tg},  32'(o_done), 32'(e_done[c]));
      chk({"rd_en ", tg}, 32'(o_rden), 32'(e_rden[c]));
      if (e_rden[c] != 0) begin
        chk({"rd_a ", tg}, 32'(o_ra), 32'(e_ra[c]));
        chk({"rd_b ", tg}, 32'(o_rb), 32'(e_rb[c]));
        chk({"zeta ", tg}, 32'(o_z),  32'(e_z[c]));
      end
      chk({"wr_en ", tg}, 32'(o_wren), 32'(e_wren[c]));
      if (e_wren[c] != 0) begin
        chk({"wr_a ", tg}, 32'(o_wa), 32'(e_wa[c]));
        chk({"wr_b ", tg}, 32'(o_wb), 32'(e_wb[c]));
      end
      if (e_busy[c] != 0) begin
        chk({"stage ", tg}, 32'(o_st), 32'(e_st[c]));
        chk({"gs ", tg},    32'(o_gs), 32'(fwd));
      end
      if (c == t)     chk({"state ", tg}, 32'(o_fsm), 32'(DONE));
      if (c == t + 1) chk({"state ", tg}, 32'(o_fsm), 32'(IDLE));
      if (o_wren) wr_cnt++;
      if (stop != 0 && c == stop) begin
        start = 1'b0;
        return;
      end
      if (c >= t - 1) begin
        start = restart;
        mode  = next_mode;
      end else if (policy == 1) begin
        start = (c < t / 2) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
        mode  = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
        mode  = 1'($urandom_range(0, 1));
      end
    end
    chk($sformatf("wr_count pl%0d", pl), 32'(wr_cnt), 32'(LOG_N * N / 2));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    sel      = 1'b0;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    chk_zero("reset pl2");
    sel = 1'b1;
    #1;
    chk_zero("reset pl3");
    sel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Forward with start held/pulsed mid-run, restart in the IDLE after DONE.
    start = 1'b1;
    mode  = 1'b1;
    check_run(1'b1, 2, 1, 1'b1, 1'b0, 0);
    // Back-to-back inverse transform.
    check_run(1'b0, 2, 0, 1'b0, 1'b0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("idle busy", 32'(o_busy), 32'd0);
      chk("idle rd_en", 32'(o_rden), 32'd0);
    end

    // Asynchronous reset at cycle 500 of a forward transform.
    start = 1'b1;
    mode  = 1'b1;
    check_run(1'b1, 2, 0, 1'b0, 1'b0, 500);
    reset_n = 1'b0;
    #1;
    chk_zero("mid reset");
    @(negedge clk);
    chk_zero("mid reset held");
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post reset wr_en", 32'(o_wren), 32'd0);
      chk("post reset busy",  32'(o_busy), 32'd0);
      chk("post reset rd_en", 32'(o_rden), 32'd0);
    end
    start = 1'b1;
    mode  = 1'b1;
    check_run(1'b1, 2, 0, 1'b0, 1'b0, 0);

    // Deeper write-back pipeline.
    @(negedge clk);
    sel   = 1'b1;
    start = 1'b1;
    mode  = 1'b1;
    check_run(1'b1, 3, 0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
